// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB and drives datapath controls.
// Optional overflow trap on add/sub write-back is enabled by defining OVERFLOW_TRAP_EN.
module multicycle_control_unit #(
    parameter int OP_W = 6,
    parameter int ST_W = 3
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            sign,
    input  logic            overFlow,
    output logic [ST_W-1:0] state,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegDSrc,
    output logic            DBDataSrc,
    output logic            mRD,
    output logic            mWR,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic [2:0]      AluOp,
    output logic            ExtSel,
    output logic [1:0]      PCSrc,
    output logic            exc
);

    localparam logic [ST_W-1:0] S_IF    = 3'b000;
    localparam logic [ST_W-1:0] S_ID    = 3'b001;
    localparam logic [ST_W-1:0] S_EXE_L = 3'b010;
    localparam logic [ST_W-1:0] S_MEM   = 3'b011;
    localparam logic [ST_W-1:0] S_WB_L  = 3'b100;
    localparam logic [ST_W-1:0] S_EXE_B = 3'b101;
    localparam logic [ST_W-1:0] S_EXE_A = 3'b110;
    localparam logic [ST_W-1:0] S_WB_A  = 3'b111;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    logic [ST_W-1:0] state_q, state_d;
    logic            alu_known, alu_rtype, alu_src_a, alu_src_b, alu_ext;
    logic [2:0]      alu_op;
    logic            br_taken, trap;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // ALU-class decode; held stable for the whole EXE_A/WB_A pair since opcode comes from IR.
    always_comb begin
        alu_known = 1'b1;
        alu_rtype = 1'b0;
        alu_op    = 3'd0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_ext   = 1'b1;
        case (opcode)
            OP_ADD:   alu_rtype = 1'b1;
            OP_SUB:   begin alu_rtype = 1'b1; alu_op = 3'd1; end
            OP_ADDIU: alu_src_b = 1'b1;
            OP_AND:   begin alu_rtype = 1'b1; alu_op = 3'd6; end
            OP_ANDI:  begin alu_op = 3'd6; alu_src_b = 1'b1; alu_ext = 1'b0; end
            OP_ORI:   begin alu_op = 3'd5; alu_src_b = 1'b1; alu_ext = 1'b0; end
            OP_SLL:   begin alu_rtype = 1'b1; alu_op = 3'd4; alu_src_a = 1'b1; end
            OP_SLT:   begin alu_rtype = 1'b1; alu_op = 3'd3; end
            OP_SLTI:  begin alu_op = 3'd3; alu_src_b = 1'b1; end
            default:  alu_known = 1'b0;
        endcase
    end

    assign br_taken = ((opcode == OP_BEQ)  &&  zero) ||
                      ((opcode == OP_BNE)  && !zero) ||
                      ((opcode == OP_BLTZ) &&  sign);

`ifdef OVERFLOW_TRAP_EN
    assign trap = (state_q == S_WB_A) && ((opcode == OP_ADD) || (opcode == OP_SUB)) && overFlow;
`else
    logic unused_overflow;
    assign unused_overflow = overFlow;
    assign trap            = 1'b0;
`endif

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_J, OP_JAL, OP_JR:     state_d = S_IF;
                    OP_BEQ, OP_BNE, OP_BLTZ: state_d = S_EXE_B;
                    OP_LW, OP_SW:            state_d = S_EXE_L;
                    OP_HALT:                 state_d = S_ID;
                    default:                 state_d = alu_known ? S_EXE_A : S_IF;
                endcase
            end
            S_EXE_L: state_d = S_MEM;
            S_MEM:   state_d = (opcode == OP_LW) ? S_WB_L : S_IF;
            S_EXE_A: state_d = S_WB_A;
            default: state_d = S_IF;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        AluOp     = 3'd0;
        ExtSel    = 1'b0;
        PCSrc     = 2'b00;
        exc       = trap;
        case (state_q)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            S_ID: begin
                case (opcode)
                    OP_J:  begin PCWre = 1'b1; PCSrc = 2'b11; end
                    OP_JR: begin PCWre = 1'b1; PCSrc = 2'b10; end
                    OP_JAL: begin
                        PCWre  = 1'b1;
                        PCSrc  = 2'b11;
                        RegWre = 1'b1;
                        RegDst = 2'b10;
                    end
                    OP_BEQ, OP_BNE, OP_BLTZ, OP_LW, OP_SW, OP_HALT: ;
                    default: PCWre = !alu_known;
                endcase
            end
            S_EXE_L, S_MEM, S_WB_L: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (state_q == S_MEM) begin
                    mWR   = (opcode == OP_SW);
                    PCWre = (opcode == OP_SW);
                    mRD   = (opcode == OP_LW);
                end
                if (state_q == S_WB_L) begin
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                end
            end
            S_EXE_B: begin
                AluOp  = 3'd1;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                PCSrc  = br_taken ? 2'b01 : 2'b00;
            end
            S_EXE_A, S_WB_A: begin
                AluOp   = alu_op;
                ALUSrcA = alu_src_a;
                ALUSrcB = alu_src_b;
                ExtSel  = alu_ext;
                if (state_q == S_WB_A) begin
                    RegWre    = !trap;
                    PCWre     = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = alu_rtype ? 2'b01 : 2'b00;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed pins plus randomized instruction streams
// compared every cycle against an instruction-step model of the control outputs.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND = 6'b010000, OP_ANDI = 6'b010001, OP_ORI = 6'b010010;
    localparam logic [5:0] OP_SLL = 6'b011000, OP_SLT = 6'b100110, OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW = 6'b110000, OP_LW = 6'b110001;
    localparam logic [5:0] OP_BEQ = 6'b110100, OP_BNE = 6'b110101, OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J = 6'b111000, OP_JR = 6'b111001, OP_JAL = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre, irwre, insmem, regwre;
        logic [1:0] regdst;
        logic       wrsrc, dbsrc, mrd, mwr, srca, srcb;
        logic [2:0] aluop;
        logic       ext;
        logic [1:0] pcsrc;
        logic       exc;
    } ctrl_t;

    logic       CLK, Reset, zero, sign, overFlow;
    logic [5:0] opcode;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, ExtSel, exc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] AluOp;

    multicycle_control_unit dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .overFlow(overFlow), .state(state), .PCWre(PCWre), .IRWre(IRWre),
        .InsMemRW(InsMemRW), .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .AluOp(AluOp), .ExtSel(ExtSel), .PCSrc(PCSrc), .exc(exc)
    );

    ctrl_t dut_v;
    assign dut_v = {state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, DBDataSrc,
                    mRD, mWR, ALUSrcA, ALUSrcB, AluOp, ExtSel, PCSrc, exc};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int    n_checks = 0;
    int    n_fail   = 0;
    ctrl_t exp_v;
    bit    exp_valid = 1'b0;
    int    k_cur     = 0;
    ctrl_t trace [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_alu(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLT, OP_SLTI};
    endfunction

    function automatic bit is_known(input logic [5:0] op);
        return is_alu(op) || (op inside {OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ,
                                         OP_J, OP_JR, OP_JAL, OP_HALT});
    endfunction

    function automatic int instr_len(input logic [5:0] op);
        if (op inside {OP_BEQ, OP_BNE, OP_BLTZ}) return 3;
        if (op == OP_SW) return 4;
        if (op == OP_LW) return 5;
        if (is_alu(op))  return 4;
        return 2;
    endfunction

    // {rtype, aluop, srcA, srcB, ext} straight from the instruction table
    function automatic logic [6:0] alu_fields(input logic [5:0] op);
        case (op)
            OP_ADD:   return 7'b1_000_0_0_1;
            OP_SUB:   return 7'b1_001_0_0_1;
            OP_ADDIU: return 7'b0_000_0_1_1;
            OP_AND:   return 7'b1_110_0_0_1;
            OP_ANDI:  return 7'b0_110_0_1_0;
            OP_ORI:   return 7'b0_101_0_1_0;
            OP_SLL:   return 7'b1_100_1_0_1;
            OP_SLT:   return 7'b1_011_0_0_1;
            default:  return 7'b0_011_0_1_1;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction (k=0 is its fetch cycle).
    function automatic ctrl_t model(input logic [5:0] op, input int k,
                                    input logic z, input logic s, input logic ov);
        ctrl_t      c;
        logic [6:0] af;
        bit         taken;
        c = '0;
        if (k == 0) begin
            c.irwre = 1'b1; c.insmem = 1'b1;
            return c;
        end
        if (k == 1 || op == OP_HALT) begin
            c.st = 3'd1;
            if (op == OP_J)  begin c.pcwre = 1; c.pcsrc = 2'b11; end
            if (op == OP_JR) begin c.pcwre = 1; c.pcsrc = 2'b10; end
            if (op == OP_JAL) begin
                c.pcwre = 1; c.pcsrc = 2'b11; c.regwre = 1; c.regdst = 2'b10;
            end
            if (!is_known(op)) c.pcwre = 1;
            return c;
        end
        if (op inside {OP_BEQ, OP_BNE, OP_BLTZ}) begin
            taken = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s);
            c.st = 3'd5; c.aluop = 3'd1; c.ext = 1; c.pcwre = 1;
            c.pcsrc = taken ? 2'b01 : 2'b00;
        end else if (op == OP_LW || op == OP_SW) begin
            c.srcb = 1; c.ext = 1;
            c.st = (k == 2) ? 3'd2 : (k == 3) ? 3'd3 : 3'd4;
            if (k == 3 && op == OP_SW) begin c.mwr = 1; c.pcwre = 1; end
            if (k == 3 && op == OP_LW) c.mrd = 1;
            if (k == 4) begin c.regwre = 1; c.dbsrc = 1; c.wrsrc = 1; c.pcwre = 1; end
        end else begin
            af = alu_fields(op);
            c.aluop = af[5:3]; c.srca = af[2]; c.srcb = af[1]; c.ext = af[0];
            c.st = (k == 2) ? 3'd6 : 3'd7;
            if (k == 3) begin
                c.regwre = 1; c.pcwre = 1; c.wrsrc = 1;
                c.regdst = af[6] ? 2'b01 : 2'b00;
`ifdef OVERFLOW_TRAP_EN
                if ((op == OP_ADD || op == OP_SUB) && ov) begin c.regwre = 0; c.exc = 1; end
`endif
            end
        end
        return c;
    endfunction

    always @(negedge CLK) begin
        if (exp_valid) begin
            check($sformatf("cycle k=%0d op=%b", k_cur, opcode), 32'(dut_v), 32'(exp_v));
            if (k_cur < 16) trace[k_cur] = dut_v;
        end
    end

    task automatic run_instr(input logic [5:0] op, input int n, input bit force_f,
                             input logic fz, input logic fs, input logic fo);
        for (int k = 0; k < n; k++) begin
            opcode = op;
            if (force_f) begin zero = fz; sign = fs; overFlow = fo; end
            else begin
                zero = 1'($urandom); sign = 1'($urandom); overFlow = 1'($urandom);
            end
            exp_v = model(op, k, zero, sign, overFlow);
            k_cur = k;
            exp_valid = 1'b1;
            @(posedge CLK); #1;
        end
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        Reset = 1'b0;
        @(posedge CLK); #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_no_regwre", 32'(RegWre), 32'd0);
        Reset = 1'b1;
    endtask

    logic [5:0] known_ops [18] = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL,
                                   OP_SLT, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ,
                                   OP_J, OP_JR, OP_JAL, OP_HALT};

    initial begin
        logic [5:0] op;
        Reset = 1'b0; opcode = 6'd0; zero = 0; sign = 0; overFlow = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("post_reset_state", 32'(state), 32'd0);
        Reset = 1'b1;
        check("post_reset_irwre", 32'(IRWre), 32'd1);
        check("post_reset_pcwre", 32'(PCWre), 32'd0);

        run_instr(OP_ADD, 4, 1'b1, 0, 0, 0);
        check("add_st1", 32'(trace[1].st), 32'd1);
        check("add_st2", 32'(trace[2].st), 32'd6);
        check("add_st3", 32'(trace[3].st), 32'd7);
        check("add_wb_regwre", 32'(trace[3].regwre), 32'd1);
        check("add_wb_regdst", 32'(trace[3].regdst), 32'd1);
        check("add_wb_aluop", 32'(trace[3].aluop), 32'd0);
        check("add_wb_pcwre", 32'(trace[3].pcwre), 32'd1);
        check("add_back_to_if", 32'(state), 32'd0);

        run_instr(OP_LW, 5, 1'b1, 0, 0, 0);
        check("lw_st2", 32'(trace[2].st), 32'd2);
        check("lw_st3", 32'(trace[3].st), 32'd3);
        check("lw_st4", 32'(trace[4].st), 32'd4);
        check("lw_mem_mrd", 32'(trace[3].mrd), 32'd1);
        check("lw_wb_dbsrc", 32'(trace[4].dbsrc), 32'd1);
        check("lw_wb_regwre", 32'(trace[4].regwre), 32'd1);
        check("lw_wb_regdst", 32'(trace[4].regdst), 32'd0);
        check("lw_back_to_if", 32'(state), 32'd0);

        run_instr(OP_BEQ, 3, 1'b1, 1, 0, 0);
        check("beq_taken_pcsrc", 32'(trace[2].pcsrc), 32'd1);
        run_instr(OP_BEQ, 3, 1'b1, 0, 0, 0);
        check("beq_not_taken_pcsrc", 32'(trace[2].pcsrc), 32'd0);
        run_instr(OP_BLTZ, 3, 1'b1, 0, 1, 0);
        check("bltz_taken_pcsrc", 32'(trace[2].pcsrc), 32'd1);

        run_instr(OP_JAL, 2, 1'b1, 0, 0, 0);
        check("jal_id_vec", 32'(trace[1]), 32'({3'd1, 4'b1001, 2'b10, 6'b0, 3'd0, 1'b0, 2'b11, 1'b0}));
        check("jal_back_to_if", 32'(state), 32'd0);

        run_instr(OP_HALT, 12, 1'b1, 0, 0, 0);
        for (int k = 2; k < 12; k++) begin
            check($sformatf("halt_state_k%0d", k), 32'(trace[k].st), 32'd1);
            check($sformatf("halt_pcwre_k%0d", k), 32'(trace[k].pcwre), 32'd0);
        end
        do_reset();

        run_instr(OP_SUB, 4, 1'b1, 0, 0, 1);
`ifdef OVERFLOW_TRAP_EN
        check("sub_ovf_exc", 32'(trace[3].exc), 32'd1);
        check("sub_ovf_regwre", 32'(trace[3].regwre), 32'd0);
`else
        check("sub_ovf_exc", 32'(trace[3].exc), 32'd0);
        check("sub_ovf_regwre", 32'(trace[3].regwre), 32'd1);
`endif
        run_instr(OP_ADDIU, 4, 1'b1, 0, 0, 1);
        check("addiu_ovf_regwre", 32'(trace[3].regwre), 32'd1);

        // Reset asserted during sw's MEM cycle: after the edge, fetch and no write
        run_instr(OP_SW, 3, 1'b1, 0, 0, 0);
        Reset = 1'b0;
        exp_v = model(OP_SW, 3, zero, sign, overFlow);
        k_cur = 3;
        exp_valid = 1'b1;
        @(posedge CLK); #1;
        exp_valid = 1'b0;
        check("sw_rst_mem_seen", 32'(trace[3].st), 32'd3);
        check("sw_rst_state", 32'(state), 32'd0);
        check("sw_rst_no_mwr", 32'(mWR), 32'd0);
        Reset = 1'b1;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                op = 6'($urandom_range(0, 63));
                while (is_known(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = known_ops[$urandom_range(0, 17)];
            end
            if (op == OP_HALT) begin
                run_instr(op, 2 + $urandom_range(0, 3), 1'b0, 0, 0, 0);
                do_reset();
            end else if ($urandom_range(0, 19) == 0) begin
                run_instr(op, 1 + $urandom_range(0, instr_len(op) - 2), 1'b0, 0, 0, 0);
                do_reset();
            end else begin
                run_instr(op, instr_len(op), 1'b0, 0, 0, 0);
                check("instr_end_in_if", 32'(state), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM of the multi-cycle CPU. It sequences every instruction through IF/ID/EXE/MEM/WB.
- Drives the execute unit's operand-select and operation inputs (ALUSrcA, ALUSrcB, AluOp).
- Consumes the execute unit's zero/sign/overFlow flags to resolve branches and overflow.
- Also drives PC, IR, register-file and data-memory enables and muxes. Sits between the instruction register and the datapath.

Parameters:
- OP_W, 6, opcode field width.
- ST_W, 3, state register width.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- opcode  input  6  IR[31:26].
- zero  input  1  execute-unit result==0.
- sign  input  1  execute-unit result[31].
- overFlow  input  1  execute-unit signed overflow (add/sub).
- state  output  3  current state, for debug.
- PCWre  output  1  PC load enable.
- IRWre  output  1  IR load enable.
- InsMemRW  output  1  instruction-memory read.
- RegWre  output  1  register-file write enable.
- RegDst  output  2  write-register select: 00 rt, 01 rd, 10 $31.
- WrRegDSrc  output  1  0 = PC+4 (jal link), 1 = DB.
- DBDataSrc  output  1  0 = execute result, 1 = data-memory out.
- mRD  output  1  data-memory read.
- mWR  output  1  data-memory write.
- ALUSrcA  output  1  1 = shamt, 0 = rs.
- ALUSrcB  output  1  1 = extended imm, 0 = rt.
- AluOp  output  3  0 add, 1 sub, 2 unsigned lt, 3 signed lt, 4 sll, 5 or, 6 and, 7 mov.
- ExtSel  output  1  1 = sign-extend, 0 = zero-extend.
- PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 {PC[31:28],addr,00}.
- exc  output  1  overflow exception flag (optional feature only; tied 0 otherwise).

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, sll 011000
  - slt 100110, slti 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
  - Any other opcode is treated as a NOP: ID->IF with PCWre=1, PCSrc=00.
- States: IF 000, ID 001, EXE_L 010, MEM 011, WB_L 100, EXE_B 101, EXE_A 110, WB_A 111.
- The state register updates on the CLK rising edge. When Reset=0 at an edge, state<=IF. All outputs are combinational from (state, opcode, flags).
- In the IF state (including during reset): IRWre=1, InsMemRW=1. All other enables are 0; AluOp=0, PCSrc=00.
- Transitions:
  - IF->ID always.
  - From ID:
    - j/jal/jr complete in ID: PCWre=1, PCSrc 11/11/10, then ->IF. jal also does RegWre=1, RegDst=10, WrRegDSrc=0.
    - beq/bne/bltz ->EXE_B.
    - lw/sw ->EXE_L.
    - halt stays in ID forever: PCWre=0, IRWre=0.
    - All others ->EXE_A.
  - EXE_A->WB_A->IF. WB_A: RegWre=1, PCWre=1, DBDataSrc=0, WrRegDSrc=1. RegDst=01 for R-type, 00 for immediate forms.
  - EXE_L: AluOp=0, ALUSrcB=1, ExtSel=1, then ->MEM.
    - sw: MEM asserts mWR=1 and PCWre=1, then ->IF.
    - lw: MEM asserts mRD=1, then ->WB_L.
  - WB_L: RegWre=1, DBDataSrc=1, RegDst=00, PCWre=1, then ->IF.
  - EXE_B (one cycle, then ->IF): AluOp=1, ALUSrcB=0, PCWre=1.
    - PCSrc=01 if taken, else 00.
    - Taken: beq zero=1; bne zero=0; bltz sign=1 (rt field is $0).
- AluOp/source selection, held constant across EXE_* and the following WB/MEM:
  - add/addiu 0; sub 1; slt/slti 3; sll 4 with ALUSrcA=1; ori 5; and/andi 6.
  - ALUSrcB=1 for all immediates. ExtSel=0 for andi/ori, 1 otherwise.
- Cycle counts: jump 2, branch 3, sw 4, ALU 4, lw 5.
- Reset mid-instruction: next edge forces IF. MEM/WB writes from the interrupted instruction are not issued after that edge.
- Flags are sampled only in EXE_B (and in WB_A with the optional feature); they are ignored elsewhere.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined:
  - In WB_A for add/sub, if overFlow=1: RegWre=0, exc=1 for that cycle, PCSrc=00, PCWre=1.
  - addiu never traps.
- Undefined:
  - exc tied 0 and overFlow ignored; the overflowed result is written back.

Test Plan:
- Reset=0 for 2 edges, then release -> state=000, IRWre=1, PCWre=0. State reaches 001 one edge later.
- add (000000) -> states 000,001,110,111,000. WB_A: RegWre=1, RegDst=01, AluOp=0, PCWre=1.
- lw (110001) -> 000,001,010,011,100,000. MEM: mRD=1. WB_L: DBDataSrc=1, RegWre=1, RegDst=00.
- beq with zero=1 -> EXE_B PCSrc=01. Repeat with zero=0 -> PCSrc=00. bltz with sign=1 -> PCSrc=01.
- jal -> ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=10, WrRegDSrc=0; next state 000. halt -> remains 001 for 10 cycles with PCWre=0.
- OVERFLOW_TRAP_EN, sub with overFlow=1 -> WB_A: exc=1, RegWre=0. Without the macro -> RegWre=1, exc=0. Also: Reset=0 during MEM of sw -> next state 000, no mWR.
